// File: rtl/sobel_pkg.sv
// Shared constants and state encoding for the Sobel frame sequencer and calculator.
package sobel_pkg;

  localparam int unsigned ImgWDefault = 640;
  localparam int unsigned ImgHDefault = 480;
  localparam int unsigned CalcLat     = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/sobel_meta_delay.sv
// Fixed-depth shift register carrying window metadata alongside the calculator pipeline.
module sobel_meta_delay #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] pipe_q [DEPTH];
  logic [WIDTH-1:0] pipe_d [DEPTH];

  always_comb begin
    pipe_d[0] = d_i;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer: tracks raster position, flags interior 3x3 windows and re-aligns
// their metadata with the calculator's fixed-latency result.
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W    = ImgWDefault,
  parameter int unsigned IMG_H    = ImgHDefault,
  parameter int unsigned CALC_LAT = CalcLat,
  localparam int unsigned CW      = $clog2(IMG_W),
  localparam int unsigned RW      = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          pix_valid_i,
  output logic          ready_o,
  output logic          win_valid_o,
  output logic          win_last_o,
  output logic [CW-1:0] win_col_o,
  output logic [RW-1:0] win_row_o,
  output logic          out_valid_o,
  output logic [CW-1:0] out_col_o,
  output logic [RW-1:0] out_row_o,
  output logic          frame_done_o,
  output logic          busy_o
);

  localparam int unsigned LW = $clog2(CALC_LAT + 1);
  localparam int unsigned MW = 1 + RW + CW;

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [LW-1:0] drain_q, drain_d;
  logic          win_valid_q, win_valid_d;
  logic          win_last_q, win_last_d;
  logic [CW-1:0] win_col_q, win_col_d;
  logic [RW-1:0] win_row_q, win_row_d;

  logic          last_col;
  logic          last_pix;
  logic          interior;
  logic [MW-1:0] meta_d;
  logic [MW-1:0] meta_q;

  assign last_col = (col_q == CW'(IMG_W - 1));
  assign last_pix = last_col && (row_q == RW'(IMG_H - 1));
  // The pixel at (r,c) completes the window centred one row up and one column left.
  assign interior = (row_q >= RW'(2)) && (col_q >= CW'(2));

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    drain_d     = drain_q;
    win_valid_d = 1'b0;
    win_last_d  = 1'b0;
    win_col_d   = win_col_q;
    win_row_d   = win_row_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          col_d   = '0;
          row_d   = '0;
        end
      end
      StRun: begin
        if (pix_valid_i) begin
          if (last_col) begin
            col_d = '0;
            row_d = last_pix ? '0 : row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
          if (interior) begin
            win_valid_d = 1'b1;
            win_col_d   = col_q - CW'(1);
            win_row_d   = row_q - RW'(1);
          end
          if (last_pix) begin
            win_last_d = 1'b1;
            state_d    = StDrain;
            drain_d    = '0;
          end
        end
      end
      StDrain: begin
        // Stay until the final window has emerged from the calculator pipeline.
        if (drain_q == LW'(CALC_LAT)) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q + LW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      col_q       <= '0;
      row_q       <= '0;
      drain_q     <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      win_col_q   <= '0;
      win_row_q   <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      drain_q     <= drain_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      win_col_q   <= win_col_d;
      win_row_q   <= win_row_d;
    end
  end

  assign meta_d = {win_valid_q, win_row_q, win_col_q};

  sobel_meta_delay #(
    .DEPTH (CALC_LAT),
    .WIDTH (MW)
  ) u_meta_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (meta_d),
    .q_o   (meta_q)
  );

  assign {out_valid_o, out_row_o, out_col_o} = meta_q;

  assign ready_o      = (state_q == StRun);
  assign busy_o       = (state_q != StIdle);
  assign frame_done_o = (state_q == StDone);
  assign win_valid_o  = win_valid_q;
  assign win_last_o   = win_last_q;
  assign win_col_o    = win_col_q;
  assign win_row_o    = win_row_q;

endmodule
